// File: rtl/conv_systolic_engine_if.sv
// Handshake and operand bundle between a requester and conv_systolic_engine.
interface conv_systolic_engine_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned K  = 3,
   parameter int unsigned N  = 4
);
   localparam int unsigned OW = 2 * DW + $clog2(K * K);

   logic                    start;
   logic                    relu_en;
   logic [N*N*DW-1:0]       a_flat;
   logic [K*K*DW-1:0]       b_flat;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OW-1:0]    out_data;
   logic                    done;

   modport master (
      output start, relu_en, a_flat, b_flat, out_ready,
      input  busy, out_valid, out_data, done
   );

   modport slave (
      input  start, relu_en, a_flat, b_flat, out_ready,
      output busy, out_valid, out_data, done
   );
endinterface

// File: rtl/conv_systolic_engine.sv
// Weight-stationary K x K systolic convolution of an N x N tile.
// Kernel rows are loaded into the PEs, input rows stream left through each
// PE row, column partial sums flow down and are summed into one result per
// window. All M*M results are buffered, then drained in raster order.
module conv_systolic_engine #(
   parameter int unsigned DW = 8,
   parameter int unsigned K  = 3,
   parameter int unsigned N  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_systolic_engine_if.slave bus
);
   localparam int unsigned M  = N - K + 1;
   localparam int unsigned MM = M * M;
   localparam int unsigned OW = 2 * DW + $clog2(K * K);
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned PW = (MM > 1) ? $clog2(MM) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, DONE} state_t;
   state_t state, state_nx;

   logic [N*N*DW-1:0]    a_lat;
   logic [K*K*DW-1:0]    b_lat;
   logic                 relu_lat;
   logic signed [DW-1:0] w [K][K];
   logic signed [DW-1:0] x [K][K];
   logic signed [OW-1:0] res_buf [MM];
   logic signed [OW-1:0] col_sum;
   logic signed [OW-1:0] win_sum;
   logic signed [OW-1:0] win_res;
   logic [CW-1:0]        ld_cnt;
   logic [CW-1:0]        row_cnt;
   logic [CW-1:0]        col_cnt;
   logic                 flush;
   logic                 win_v;
   logic [PW-1:0]        win_idx;
   logic [PW-1:0]        rd_ptr;

   // State register; reset wins over any start on the same edge.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nx      = state;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      bus.done      = 1'b0;
      case (state)
         IDLE:    if (bus.start) state_nx = LOAD;
         LOAD: begin
            bus.busy = 1'b1;
            if (ld_cnt == CW'(K - 1)) state_nx = COMPUTE;
         end
         COMPUTE: begin
            bus.busy = 1'b1;
            if (flush) state_nx = OUTPUT;
         end
         OUTPUT: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready && rd_ptr == PW'(MM - 1)) state_nx = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      bus.out_data = bus.out_valid ? res_buf[rd_ptr] : '0;
   end

   // PE array reduction: partial sums run down each column, columns are summed.
   always_comb begin
      win_sum = '0;
      col_sum = '0;
      for (int unsigned v = 0; v < K; v++) begin
         col_sum = '0;
         for (int unsigned u = 0; u < K; u++) begin
            col_sum = col_sum + OW'(x[u][v]) * OW'(w[u][v]);
         end
         win_sum = win_sum + col_sum;
      end
      win_res = (relu_lat && win_sum < 0) ? '0 : win_sum;
   end

   // Operand latching, kernel load, data streaming, result capture, drain pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat    <= '0;
         b_lat    <= '0;
         relu_lat <= 1'b0;
         ld_cnt   <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         flush    <= 1'b0;
         win_v    <= 1'b0;
         win_idx  <= '0;
         rd_ptr   <= '0;
         for (int unsigned u = 0; u < K; u++) begin
            for (int unsigned v = 0; v < K; v++) begin
               w[u][v] <= '0;
               x[u][v] <= '0;
            end
         end
         for (int unsigned i = 0; i < MM; i++) res_buf[i] <= '0;
      end else begin
         win_v <= 1'b0;
         // A window completed by last cycle's shift is written one cycle later,
         // which is why COMPUTE ends with a single flush cycle.
         if (win_v) res_buf[win_idx] <= win_res;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_lat    <= bus.a_flat;
                  b_lat    <= bus.b_flat;
                  relu_lat <= bus.relu_en;
                  ld_cnt   <= '0;
                  row_cnt  <= '0;
                  col_cnt  <= '0;
                  flush    <= 1'b0;
                  rd_ptr   <= '0;
               end
            end
            LOAD: begin
               for (int unsigned u = 0; u < K; u++) begin
                  if (ld_cnt == CW'(u)) begin
                     for (int unsigned v = 0; v < K; v++) begin
                        w[u][v] <= b_lat[(u * K + v) * DW +: DW];
                     end
                  end
               end
               ld_cnt <= ld_cnt + 1'b1;
            end
            COMPUTE: begin
               if (!flush) begin
                  for (int unsigned u = 0; u < K; u++) begin
                     for (int unsigned v = 0; v + 1 < K; v++) begin
                        x[u][v] <= x[u][v + 1];
                     end
                     x[u][K - 1] <= a_lat[((32'(row_cnt) + u) * N + 32'(col_cnt)) * DW +: DW];
                  end
                  win_v   <= (col_cnt >= CW'(K - 1));
                  win_idx <= PW'(32'(row_cnt) * M + 32'(col_cnt) - (K - 1));
                  if (col_cnt == CW'(N - 1)) begin
                     col_cnt <= '0;
                     if (row_cnt == CW'(M - 1)) flush <= 1'b1;
                     else                       row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (bus.out_ready) rd_ptr <= rd_ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_systolic_engine.sv
// Directed bench for conv_systolic_engine with a queue scoreboard of expected results.
module tb_conv_systolic_engine;
   localparam int unsigned DW  = 8;
   localparam int unsigned K   = 3;
   localparam int unsigned N   = 4;
   localparam int unsigned M   = N - K + 1;
   localparam int unsigned MM  = M * M;
   localparam int unsigned OW  = 2 * DW + $clog2(K * K);
   localparam int unsigned LAT = 2 * N * N + 2 * K;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic signed [OW-1:0] exp_q [$];

   conv_systolic_engine_if #(.DW(DW), .K(K), .N(N)) bus ();

   conv_systolic_engine #(.DW(DW), .K(K), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [OW-1:0] ref_conv(input logic [N*N*DW-1:0] a,
                                                     input logic [K*K*DW-1:0] b,
                                                     input int unsigned i, input int unsigned j,
                                                     input logic relu);
      longint s = 0;
      logic signed [DW-1:0] ae, be;
      for (int unsigned u = 0; u < K; u++) begin
         for (int unsigned v = 0; v < K; v++) begin
            ae = a[((i + u) * N + j + v) * DW +: DW];
            be = b[(u * K + v) * DW +: DW];
            s  = s + longint'(ae) * longint'(be);
         end
      end
      if (relu && s < 0) s = 0;
      return OW'(s);
   endfunction

   // Called at a falling edge; leaves the bench at the falling edge of the cycle after done.
   task automatic run_op(input logic [N*N*DW-1:0] a, input logic [K*K*DW-1:0] b,
                         input logic relu, input int unsigned stall, input bit disturb,
                         input string tag);
      int unsigned n;
      logic signed [OW-1:0] e;
      bus.a_flat  = a;
      bus.b_flat  = b;
      bus.relu_en = relu;
      bus.start   = 1'b1;
      for (int unsigned i = 0; i < M; i++)
         for (int unsigned j = 0; j < M; j++)
            exp_q.push_back(ref_conv(a, b, i, j, relu));
      for (n = 1; n <= LAT + 2; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check({tag, "_busy_after_start"}, bus.busy, 1);
            if (disturb) begin
               bus.a_flat  = ~a;
               bus.b_flat  = '0;
               bus.relu_en = ~relu;
            end else begin
               bus.start = 1'b0;
            end
         end
         if (bus.out_valid) break;
      end
      bus.start = 1'b0;
      check({tag, "_first_valid_in_time"}, (bus.out_valid && n <= LAT + 1), 1);
      if (!bus.out_valid) begin
         exp_q.delete();
         return;
      end
      bus.out_ready = (stall == 0);
      for (int unsigned s = 0; s < stall; s++) begin
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_data"}, bus.out_data, exp_q[0]);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      for (int unsigned k = 0; k < MM; k++) begin
         if (k > 0) @(negedge clk);
         check({tag, "_valid"}, bus.out_valid, 1);
         e = exp_q.pop_front();
         check({tag, "_data"}, bus.out_data, e);
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 1);
      check({tag, "_busy_at_done"}, bus.busy, 0);
      check({tag, "_valid_at_done"}, bus.out_valid, 0);
      check({tag, "_data_zero_at_done"}, bus.out_data, 0);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_done_one_cycle"}, bus.done, 0);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   logic [N*N*DW-1:0] a_r, a_m1, a_128;
   logic [K*K*DW-1:0] b_1, b_c2, b_128;

   // Directed sequence of operations.
   initial begin
      for (int unsigned i = 0; i < N * N; i++) a_r[i*DW +: DW] = DW'(i + 1);
      a_m1  = '1;
      a_128 = {N*N{8'h80}};
      b_1   = {K*K{8'h01}};
      b_128 = {K*K{8'h80}};
      b_c2  = '0;
      b_c2[(1 * K + 1)*DW +: DW] = 8'h02;

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.relu_en   = 1'b0;
      bus.a_flat    = '0;
      bus.b_flat    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_valid", bus.out_valid, 0);
      check("reset_done", bus.done, 0);
      check("reset_data", bus.out_data, 0);
      rst = 1'b0;

      run_op(a_r, b_1, 1'b0, 0, 1'b0, "raster");
      check("raster_ref_c00", ref_conv(a_r, b_1, 0, 0, 1'b0), 54);
      run_op(a_m1, b_c2, 1'b0, 0, 1'b0, "neg");
      run_op(a_m1, b_c2, 1'b1, 0, 1'b0, "relu");
      run_op(a_128, b_128, 1'b0, 0, 1'b0, "maxmag");
      run_op(a_r, b_1, 1'b0, 5, 1'b0, "stall");
      run_op(a_r, b_1, 1'b0, 0, 1'b1, "ignore");

      bus.a_flat  = a_r;
      bus.b_flat  = b_1;
      bus.relu_en = 1'b0;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      check("midrst_busy_before", bus.busy, 1);
      rst       = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      check("midrst_busy", bus.busy, 0);
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_data", bus.out_data, 0);
      @(negedge clk);
      check("midrst_start_not_taken", bus.busy, 0);
      run_op(a_r, b_1, 1'b0, 0, 1'b0, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
